wasm_mem_lsu: RTL
=================

# wasm_mem_lsu

Load/store unit between the WASM CPU execute stage and the word-organised `simple_ram`. It accepts byte-addressed i32 loads and stores of 8, 16 or 32 bits, checks alignment and bounds, and issues word accesses to the RAM. Sub-word stores are done as read-modify-write. Sub-word loads are sign- or zero-extended. Bad accesses return an error (WASM trap) without touching memory.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: RAM word-address width; memory size is 4<<ADDR_WIDTH bytes.
- `DATA_WIDTH`, default 32: word width; fixed at 32.

Ports:
- `clk`  in  1  clock. The block uses one clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- `req_signed`  in  1  sign-extend a sub-word load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; only the low bits for the access size are used.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  access was misaligned, out of bounds or used size 3.
- `ram_we`  out  1  to `simple_ram.we`.
- `ram_addr`  out  ADDR_WIDTH  word address, equal to req_addr[ADDR_WIDTH+1:2].
- `ram_din`  out  32  to `simple_ram.din`.
- `ram_dout`  in  32  from `simple_ram.dout`; valid one cycle after the address is presented.

## Operation
- States: IDLE, RD, WAIT, WR, RESP.
- `req_ready` = (state == IDLE). A request is accepted on a clock edge where `req_valid && req_ready`. At that edge the block latches we, size, signed, addr and wdata.
- Error check at acceptance:
  - size 3 → error.
  - addr not a multiple of the access size in bytes → error.
  - addr ≥ 4<<ADDR_WIDTH → error.
- Error path: IDLE → RESP with `resp_err` = 1. No RAM access.
- Load path: IDLE → RD → WAIT → RESP.
  - RD presents `ram_addr`.
  - At the WAIT→RESP edge the block extracts and extends the data and registers it into `resp_rdata`.
- Word store path: IDLE → WR → RESP.
  - WR drives `ram_we` = 1 and `ram_din` = wdata.
- Sub-word store path: IDLE → RD → WAIT → WR → RESP.
  - The merged word is registered at the WAIT→WR edge.
  - The merge replaces the selected byte or half with the wdata low bits and keeps the other lanes.
- Byte lanes are little-endian:
  - Byte lane = addr[1:0], bits [8·lane+7 : 8·lane].
  - Half lane = addr[1], bits [16·addr[1]+15 : 16·addr[1]].
- Extension: `req_signed` = 1 replicates the top bit of the extracted field; 0 zero-fills. `req_signed` is ignored for word accesses and stores.
- RESP: `resp_valid` = 1. `resp_rdata` and `resp_err` are held stable until the edge where `resp_ready` = 1, then the state returns to IDLE.
- At most one request is in flight. No new request is accepted while in RESP.
- `ram_addr` is driven from the latched address in every state, so it is stable. `ram_we` is high only in WR.

## Timing
- Reset values: state = IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, `ram_we` = 0, `ram_addr` = 0, `ram_din` = 0.
- Reset is asynchronous. Asserting `rst_n` low in any state forces the reset values immediately, including `ram_we` = 0. An in-progress write therefore does not reach memory unless the WR edge has already passed.
- Latency is counted from the accept edge to the first cycle with `resp_valid` high:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- If `resp_ready` is already high, RESP lasts exactly one cycle and `req_ready` rises the next cycle. Peak rate is one load every 4 cycles.
- `resp_ready` asserted outside RESP has no effect.

## Structure
- Package `wasm_mem_pkg` holds:
  - the size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum;
  - a function that computes the alignment/bounds error from size and address.
- Sub-module `wasm_mem_align` is purely combinational. It takes word, lane, size and signed, and produces the extended load value. It also takes old word, wdata, lane and size, and produces the merged store word. The FSM lives in `wasm_mem_lsu`.
- `simple_ram` is instantiated outside this block, and the bench connects the two.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load word from 0x10:
  - `ram_we` pulses once with `ram_addr` = 4;
  - store response after 2 cycles;
  - load returns 0xDEADBEEF after 3 cycles with err = 0.
- Store byte 0xAA at 0x13 onto that word:
  - memory word becomes 0xAADEBEEF ... correction: 0xAAADBEEF (byte 3 replaced);
  - load8_s from 0x13 returns 0xFFFFFFAA;
  - load8_u from 0x13 returns 0x000000AA.
- load16_s from 0x12 returns 0xFFFFAAAD. load16_u from 0x10 returns 0x0000BEEF.
- Error accesses, each giving `resp_err` = 1 after 1 cycle, `resp_rdata` = 0 and no `ram_we` pulse:
  - half at 0x11;
  - word at 0x1000 with ADDR_WIDTH = 10;
  - size 3.
- Hold `resp_ready` low for 5 cycles during a load:
  - `resp_valid`/`resp_rdata` stay stable;
  - `req_ready` stays 0;
  - a `req_valid` pulse during that time is ignored.
- Assert `rst_n` low during WAIT of a byte store to 0x10:
  - outputs take their reset values at once;
  - no `ram_we` pulse;
  - a subsequent load from 0x10 returns the old value.

Source files
------------

// File: rtl/wasm_mem_pkg.sv
// Shared encodings, FSM states and access-check helper for the WASM load/store unit.
package wasm_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WAIT,
      ST_WR,
      ST_RESP
   } state_t;

   // Trap condition: illegal size, address not a multiple of the access size,
   // or address past the end of a 4<<aw byte memory.
   function automatic logic access_err(input logic [1:0]  size,
                                       input logic [31:0] addr,
                                       input int unsigned aw);
      logic e;
      e = 1'b0;
      case (size)
         SZ_BYTE: e = 1'b0;
         SZ_HALF: e = addr[0];
         SZ_WORD: e = |addr[1:0];
         default: e = 1'b1;
      endcase
      if ((addr >> (aw + 2)) != 32'd0) e = 1'b1;
      return e;
   endfunction

endpackage

// File: rtl/wasm_mem_align.sv
// Byte-lane steering: extracts/extends sub-word loads and merges sub-word stores.
module wasm_mem_align
   import wasm_mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_old,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_merged
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Select the addressed little-endian lane and sign/zero extend it
   always_comb begin
      w_byte = 8'h00;
      w_half = 16'h0000;
      o_load = i_word;
      case (i_lane)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
      case (i_size)
         SZ_BYTE: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
         SZ_HALF: o_load = {{16{i_signed & w_half[15]}}, w_half};
         default: o_load = i_word;
      endcase
   end

   // Replace the addressed byte/half of the old word with the store data
   always_comb begin
      o_merged = i_old;
      case (i_size)
         SZ_BYTE: begin
            case (i_lane)
               2'd0:    o_merged[7:0]   = i_wdata[7:0];
               2'd1:    o_merged[15:8]  = i_wdata[7:0];
               2'd2:    o_merged[23:16] = i_wdata[7:0];
               default: o_merged[31:24] = i_wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
            else           o_merged[15:0]  = i_wdata[15:0];
         end
         default: o_merged = i_wdata;
      endcase
   end

endmodule

// File: rtl/wasm_mem_lsu.sv
// Load/store unit: one request in flight, word RAM access, RMW for sub-word stores.
module wasm_mem_lsu
   import wasm_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   state_t                r_state, w_state_nxt;
   logic                  r_we;
   logic [1:0]            r_size;
   logic                  r_signed;
   logic [ADDR_WIDTH+1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [31:0]           r_din;
   logic [31:0]           r_rdata;
   logic                  r_err;

   logic                  w_accept;
   logic                  w_err;
   logic [31:0]           w_load;
   logic [31:0]           w_merged;

   assign w_accept   = req_valid && (r_state == ST_IDLE);
   assign w_err      = access_err(req_size, req_addr, ADDR_WIDTH);

   assign req_ready  = (r_state == ST_IDLE);
   assign resp_valid = (r_state == ST_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;
   // Write strobe decoded from state so an async reset kills it immediately
   assign ram_we     = (r_state == ST_WR);
   assign ram_addr   = r_addr[ADDR_WIDTH+1:2];
   assign ram_din    = r_din;

   wasm_mem_align u_align (
      .i_word   (ram_dout),
      .i_lane   (r_addr[1:0]),
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_old    (ram_dout),
      .i_wdata  (r_wdata),
      .o_load   (w_load),
      .o_merged (w_merged)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state: errors skip the RAM, word stores skip the read, the rest read first
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               if (w_err)                              w_state_nxt = ST_RESP;
               else if (req_we && req_size == SZ_WORD) w_state_nxt = ST_WR;
               else                                    w_state_nxt = ST_RD;
            end
         end
         ST_RD:   w_state_nxt = ST_WAIT;
         ST_WAIT: w_state_nxt = r_we ? ST_WR : ST_RESP;
         ST_WR:   w_state_nxt = ST_RESP;
         ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Request latch, load result capture and store word capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we     <= 1'b0;
         r_size   <= SZ_BYTE;
         r_signed <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_din    <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else if (w_accept) begin
         r_we     <= req_we;
         r_size   <= req_size;
         r_signed <= req_signed;
         r_addr   <= req_addr[ADDR_WIDTH+1:0];
         r_wdata  <= req_wdata;
         r_rdata  <= '0;
         r_err    <= w_err;
         if (req_we && req_size == SZ_WORD && !w_err) r_din <= req_wdata;
      end else if (r_state == ST_WAIT) begin
         if (r_we) r_din   <= w_merged;
         else      r_rdata <= w_load;
      end
   end

endmodule
